// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC sequencer and its interrupt encoder.
// Combinational definitions only; no latency or backpressure of its own.
package pc_seq_pkg;

    localparam int ADDR_W      = 8;
    localparam int DEF_MAX_LEN = 3;
    localparam int DEF_NUM_IRQ = 2;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_FETCH_N,
        ST_DONE,
        ST_IRQ
    } state_t;

    localparam logic [3:0] OP_BRX  = 4'd9;
    localparam logic [3:0] OP_LOOP = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;

    localparam logic [1:0] PC_SRC_RB_EX  = 2'd0;
    localparam logic [1:0] PC_SRC_VEC    = 2'd1;
    localparam logic [1:0] PC_SRC_RB_DEC = 2'd2;
    localparam logic [1:0] PC_SRC_STACK  = 2'd3;

    localparam int ADDR_SRC_PC    = 0;
    localparam int ADDR_SRC_RESET = 1;
    localparam int ADDR_SRC_IRQ0  = 2;

endpackage

// File: rtl/irq_prio_enc.sv
// Pending-interrupt register with lowest-index priority and one-hot ack.
// Encoder output is combinational (pending | irq); ack clears on the next edge unless the line is still high.
module irq_prio_enc
    import pc_seq_pkg::*;
#(
    parameter int NUM_IRQ = DEF_NUM_IRQ,
    parameter int IRQ_IW  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ack_en,
    input  logic [IRQ_IW-1:0]  ack_idx,
    output logic               any_pending,
    output logic [IRQ_IW-1:0]  irq_idx,
    output logic [NUM_IRQ-1:0] irq_ack
);

    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pend_eff;

    // A request arriving this cycle is visible to the boundary decision immediately.
    assign pend_eff    = pending_q | irq;
    assign any_pending = |pend_eff;

    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_eff[i]) irq_idx = IRQ_IW'(i);
        end
    end

    always_comb begin
        irq_ack = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            irq_ack[i] = ack_en && (ack_idx == IRQ_IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= (pending_q & ~irq_ack) | irq;
    end

endmodule

// File: rtl/pc_seq.sv
// PC sequencer: variable-length fetch, branch/jump resolution and prioritised interrupt entry.
// L+1 cycles per length-L instruction; every fetch/vector state stalls while mem_ready is low.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int  MAX_LEN = DEF_MAX_LEN,
    parameter int  NUM_IRQ = DEF_NUM_IRQ,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int IDX_W   = $clog2(MAX_LEN),
    localparam int VEC_W   = $clog2(NUM_IRQ + 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         opcode,
    input  logic [1:0]         brx,
    input  logic [LEN_W-1:0]   instr_len,
    input  logic               z_flag,
    input  logic               n_flag,
    input  logic               c_flag,
    input  logic               v_flag,
    input  logic               mem_ready,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               irq_en,
    output logic               pc_en,
    output logic               pc_load,
    output logic [1:0]         pc_src,
    output logic [VEC_W-1:0]   addr_src,
    output logic               if_en,
    output logic [IDX_W-1:0]   byte_idx,
    output logic               instr_done,
    output logic [NUM_IRQ-1:0] irq_ack
);

    localparam int IRQ_IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, len_q, len_eff;
    logic              loaded_q;
    logic [IRQ_IW-1:0] irq_sel_q, irq_idx;
    logic              any_pending, ack_en;
    logic              take, last_byte;
    logic [1:0]        br_src;
    logic [3:0]        flags;

    // Out-of-range lengths fall back to a single-byte instruction.
    assign len_eff   = (instr_len == '0 || instr_len > LEN_W'(MAX_LEN)) ? LEN_W'(1) : instr_len;
    assign last_byte = (cnt_q + LEN_W'(1)) == len_q;
    assign flags     = {v_flag, c_flag, n_flag, z_flag};
    assign ack_en    = !reset && (state_q == ST_IRQ) && mem_ready;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IRQ_IW  (IRQ_IW)
    ) u_irq (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .ack_en      (ack_en),
        .ack_idx     (irq_sel_q),
        .any_pending (any_pending),
        .irq_idx     (irq_idx),
        .irq_ack     (irq_ack)
    );

    always_comb begin
        take   = 1'b0;
        br_src = PC_SRC_RB_EX;
        case (opcode)
            OP_BRX:  take = flags[brx];
            OP_LOOP: take = !z_flag;
            OP_JMP: begin
                take   = 1'b1;
                br_src = (brx < 2'd2) ? PC_SRC_RB_DEC : PC_SRC_STACK;
            end
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:   if (mem_ready) state_d = ST_FETCH;
            ST_FETCH:   if (mem_ready) state_d = (len_eff > LEN_W'(1)) ? ST_FETCH_N : ST_DONE;
            ST_FETCH_N: if (mem_ready && last_byte) state_d = ST_DONE;
            // The branch load is applied in DONE itself, so vectoring here never drops it.
            ST_DONE:    state_d = (irq_en && any_pending) ? ST_IRQ : ST_FETCH;
            ST_IRQ:     if (mem_ready) state_d = ST_FETCH;
            default:    state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            len_q     <= LEN_W'(1);
            loaded_q  <= 1'b1;
            irq_sel_q <= '0;
        end else begin
            if (pc_en && pc_load)
                loaded_q <= 1'b1;
            else if (state_q == ST_FETCH && mem_ready)
                loaded_q <= 1'b0;

            if (state_q == ST_FETCH && mem_ready) begin
                len_q <= len_eff;
                cnt_q <= LEN_W'(1);
            end else if (state_q == ST_FETCH_N && mem_ready) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end

            // Latch the winner so the vector and ack agree even if a new request lands while waiting.
            if (state_q == ST_DONE) irq_sel_q <= irq_idx;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        pc_src     = PC_SRC_RB_EX;
        addr_src   = VEC_W'(ADDR_SRC_PC);
        if_en      = 1'b0;
        byte_idx   = '0;
        instr_done = 1'b0;
        if (reset || state_q == ST_RESET) begin
            pc_en    = 1'b1;
            pc_load  = 1'b1;
            pc_src   = PC_SRC_VEC;
            addr_src = VEC_W'(ADDR_SRC_RESET);
            if_en    = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if_en = 1'b1;
                    pc_en = mem_ready && !loaded_q;
                end
                ST_FETCH_N: begin
                    if_en    = 1'b1;
                    byte_idx = cnt_q[IDX_W-1:0];
                    pc_en    = mem_ready;
                end
                ST_DONE: begin
                    instr_done = 1'b1;
                    pc_en      = take;
                    pc_load    = take;
                    pc_src     = take ? br_src : PC_SRC_RB_EX;
                end
                ST_IRQ: begin
                    pc_en    = 1'b1;
                    pc_load  = 1'b1;
                    pc_src   = PC_SRC_VEC;
                    addr_src = VEC_W'(ADDR_SRC_IRQ0) + VEC_W'(irq_sel_q);
                end
                default: pc_en = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Randomised scoreboard bench for pc_seq: an instruction-level model queues expected output events,
// and a negedge monitor compares every cycle where the DUT writes the PC, finishes or acks.
module tb_pc_seq;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic [1:0] brx;
    logic [1:0] instr_len;
    logic       z_flag, n_flag, c_flag, v_flag;
    logic       mem_ready;
    logic [1:0] irq;
    logic       irq_en;
    logic       pc_en, pc_load, if_en, instr_done;
    logic [1:0] pc_src, addr_src, byte_idx, irq_ack;

    pc_seq dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .brx        (brx),
        .instr_len  (instr_len),
        .z_flag     (z_flag),
        .n_flag     (n_flag),
        .c_flag     (c_flag),
        .v_flag     (v_flag),
        .mem_ready  (mem_ready),
        .irq        (irq),
        .irq_en     (irq_en),
        .pc_en      (pc_en),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .addr_src   (addr_src),
        .if_en      (if_en),
        .byte_idx   (byte_idx),
        .instr_done (instr_done),
        .irq_ack    (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event layout: {pc_en, pc_load, pc_src, addr_src, if_en, byte_idx, instr_done, irq_ack}
    typedef logic [12:0] ev_t;
    localparam ev_t RST_EV = 13'b1_1_01_01_1_00_0_00;

    function automatic ev_t mk(bit en, bit ld, logic [1:0] src, logic [1:0] asrc,
                               bit ifen, logic [1:0] bi, bit dn, logic [1:0] ack);
        return {en, ld, src, asrc, ifen, bi, dn, ack};
    endfunction

    ev_t  expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;
    bit   rst_chk  = 1'b0;
    bit   abort    = 1'b0;

    logic [1:0] m_pend;
    bit         m_loaded;
    bit         m_take;
    int         m_k;

    always @(negedge clk) begin
        ev_t got, exp_ev;
        got = {pc_en, pc_load, pc_src, addr_src, if_en, byte_idx, instr_done, irq_ack};
        if (rst_chk) begin
            n_checks++;
            if (got !== RST_EV) begin
                n_fail++;
                $display("FAIL reset_decode t=%0t got=%b required=%b", $time, got, RST_EV);
            end
        end else if (mon_on && (pc_en || instr_done || irq_ack != 2'b00)) begin
            n_checks++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event t=%0t got=%b required=<none>", $time, got);
            end else begin
                exp_ev = expq.pop_front();
                if (got !== exp_ev) begin
                    n_fail++;
                    $display("FAIL event t=%0t got=%b required=%b (en ld src asrc if bi dn ack)",
                             $time, got, exp_ev);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        mon_on  = 1'b0;
        reset   = 1'b1;
        irq     = 2'b00;
        rst_chk = 1'b1;
        repeat (n) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst_chk   = 1'b0;
        reset     = 1'b0;
        mem_ready = 1'b1;
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events got=%0d required=0", expq.size());
        end
        expq.delete();
        m_pend   = 2'b00;
        m_loaded = 1'b1;
        m_take   = 1'b0;
        expq.push_back(RST_EV);
        mon_on = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One instruction: queue its expected events from the rules, then drive it until instr_done.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] b, input logic [1:0] len,
                             input logic [3:0] fl, input logic [1:0] pulse, input bit ien);
        bit         irq_cyc, tk, done, first;
        logic [1:0] src;
        int         leff, cyc;
        if (abort) return;
        irq_cyc = m_take;
        if (m_take) begin
            expq.push_back(mk(1, 1, 2'd1, 2'(2 + m_k), 0, 2'd0, 0, 2'(1 << m_k)));
            m_pend[m_k] = 1'b0;
        end
        m_pend = m_pend | pulse;
        leff = (len == 0) ? 1 : int'(len);
        if (!m_loaded) expq.push_back(mk(1, 0, 2'd0, 2'd0, 1, 2'd0, 0, 2'd0));
        for (int bi = 1; bi < leff; bi++)
            expq.push_back(mk(1, 0, 2'd0, 2'd0, 1, 2'(bi), 0, 2'd0));
        tk  = 1'b0;
        src = 2'd0;
        if (op == 4'd9)       tk = fl[b];
        else if (op == 4'd10) tk = !fl[0];
        else if (op == 4'd11) begin
            tk  = 1'b1;
            src = (b < 2) ? 2'd2 : 2'd3;
        end
        expq.push_back(mk(tk, tk, src, 2'd0, 0, 2'd0, 1, 2'd0));
        m_loaded = tk;
        m_take   = 1'b0;
        if (ien && m_pend != 2'b00) begin
            m_take   = 1'b1;
            m_loaded = 1'b1;
            for (int i = 1; i >= 0; i--) if (m_pend[i]) m_k = i;
        end

        opcode    = op;
        brx       = b;
        instr_len = len;
        {v_flag, c_flag, n_flag, z_flag} = fl;
        irq       = pulse;
        irq_en    = ien;
        mem_ready = irq_cyc ? 1'b1 : ($urandom_range(0, 3) != 0);
        done  = 1'b0;
        first = 1'b1;
        cyc   = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            done = instr_done;
            @(posedge clk);
            #1;
            if (first) irq = 2'b00;
            first = 1'b0;
            cyc++;
            if (!done) mem_ready = ($urandom_range(0, 3) != 0);
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            abort = 1'b1;
            $display("FAIL instr_timeout got=%0d cycles required=<100 op=%0d len=%0d", cyc, op, len);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 4'd0; brx = 2'd0; instr_len = 2'd1;
        z_flag = 0; n_flag = 0; c_flag = 0; v_flag = 0;
        mem_ready = 1'b1; irq = 2'b00; irq_en = 1'b0;

        do_reset(3);
        run_instr(4'd0, 2'd0, 2'd1, 4'b0000, 2'b00, 0);
        run_instr(4'd0, 2'd0, 2'd2, 4'b0000, 2'b00, 0);
        run_instr(4'd0, 2'd0, 2'd3, 4'b0000, 2'b00, 0);
        run_instr(4'd9, 2'd2, 2'd1, 4'b0100, 2'b00, 0);
        run_instr(4'd9, 2'd2, 2'd2, 4'b0000, 2'b00, 0);
        run_instr(4'd11, 2'd0, 2'd2, 4'b0000, 2'b11, 1);
        run_instr(4'd0, 2'd0, 2'd1, 4'b0000, 2'b00, 1);
        run_instr(4'd0, 2'd0, 2'd1, 4'b0000, 2'b00, 0);
        run_instr(4'd0, 2'd0, 2'd1, 4'b0000, 2'b01, 0);
        run_instr(4'd0, 2'd0, 2'd2, 4'b0000, 2'b00, 0);
        run_instr(4'd0, 2'd0, 2'd1, 4'b0000, 2'b00, 1);
        run_instr(4'd10, 2'd0, 2'd2, 4'b0000, 2'b00, 0);
        run_instr(4'd10, 2'd0, 2'd2, 4'b0001, 2'b00, 0);
        run_instr(4'd11, 2'd3, 2'd1, 4'b0000, 2'b00, 0);
        run_instr(4'd0, 2'd0, 2'd0, 4'b0000, 2'b00, 0);

        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 5) < 4) ? 4'(9 + $urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            run_instr(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      ($urandom_range(0, 2) != 0));
        end

        // Reset lands in the IRQ cycle: the pending request must be dropped without an ack.
        run_instr(4'd0, 2'd0, 2'd1, 4'b0000, 2'b01, 1);
        if (!abort) do_reset(2);
        run_instr(4'd0, 2'd0, 2'd1, 4'b0000, 2'b00, 1);
        run_instr(4'd0, 2'd0, 2'd2, 4'b0000, 2'b00, 0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL events_outstanding got=%0d required=0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
